// File: rtl/line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module   : line_window_3x3
// Brief    : Streaming 3x3 window generator over two line buffers, no padding.
// Revision : 1.0 - initial release
// ============================================================================
module line_window_3x3 #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid_in,
    input  logic        pixel_sof_in,
    output logic [71:0] pixel_data_out,
    output logic        pixel_data_valid_out,
    output logic        frame_done_out
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] c_COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_ROW_ONE  = ROW_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic [7:0]       r_lb1 [0:IMG_W-1];
    logic [7:0]       r_lb2 [0:IMG_W-1];
    logic [7:0]       r_win [0:8];
    logic [7:0]       w_win_next [0:8];
    logic [71:0]      w_win_flat;

    logic             w_sof;
    logic             w_acc;
    logic             w_col_last;
    logic             w_row_last;
    logic [COL_W-1:0] w_addr;
    logic [7:0]       w_lb1_rd;
    logic [7:0]       w_lb2_rd;
    logic             w_emit;
    logic             w_done;

    // A sof pixel always restarts at (0,0), regardless of the current state.
    assign w_sof      = pixel_valid_in & pixel_sof_in;
    assign w_acc      = pixel_valid_in & (w_sof | (r_state != S_IDLE));
    assign w_addr     = w_sof ? '0 : r_col;
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);
    assign w_lb1_rd   = r_lb1[w_addr];
    assign w_lb2_rd   = r_lb2[w_addr];

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (pixel_valid_in) begin
            case (r_state)
                S_IDLE: begin
                    if (w_sof) begin
                        w_state_next = S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_sof) begin
                        w_state_next = S_FILL;
                    end else if (w_col_last && (r_row == c_ROW_ONE)) begin
                        w_state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_sof) begin
                        w_state_next = S_FILL;
                    end else if (w_col_last && w_row_last) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_emit = 1'b0;
        w_done = 1'b0;
        if (pixel_valid_in && !w_sof && (r_state == S_RUN) && (r_col >= c_COL_TWO)) begin
            w_emit = 1'b1;
            w_done = w_col_last & w_row_last;
        end
    end

    // ------------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_sof) begin
                r_col <= COL_W'(1);
                r_row <= '0;
            end else if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : (r_row + ROW_W'(1));
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers: read-before-write at the same address
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_acc) begin
            r_lb2[w_addr] <= w_lb1_rd;
            r_lb1[w_addr] <= pixel_in;
        end
    end

    // ------------------------------------------------------------------------
    // Window shift register
    // ------------------------------------------------------------------------
    always_comb begin
        w_win_next[0] = r_win[1];
        w_win_next[1] = r_win[2];
        w_win_next[2] = w_lb2_rd;
        w_win_next[3] = r_win[4];
        w_win_next[4] = r_win[5];
        w_win_next[5] = w_lb1_rd;
        w_win_next[6] = r_win[7];
        w_win_next[7] = r_win[8];
        w_win_next[8] = pixel_in;
    end

    always_comb begin
        w_win_flat = '0;
        for (int k = 0; k < 9; k++) begin
            w_win_flat[k*8 +: 8] = w_win_next[k];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= 8'h00;
            end
        end else if (w_acc) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= w_win_next[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_data_out       <= '0;
            pixel_data_valid_out <= 1'b0;
            frame_done_out       <= 1'b0;
        end else begin
            pixel_data_valid_out <= w_emit;
            frame_done_out       <= w_done;
            if (w_emit) begin
                pixel_data_out <= w_win_flat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_window_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_3x3
// Brief    : Self-checking bench: vector table plus frame-model scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_window_3x3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix;
    logic        pv;
    logic        psof;
    logic        sel;

    logic [71:0] s_data, b_data, m_data;
    logic        s_v, s_d, b_v, b_d, m_valid, m_done;

    always #5 clk = ~clk;

    line_window_3x3 #(.IMG_W(4), .IMG_H(3)) u_small (
        .clk_in               (clk),
        .rst_in               (rst),
        .pixel_in             (pix),
        .pixel_valid_in       (pv & ~sel),
        .pixel_sof_in         (psof),
        .pixel_data_out       (s_data),
        .pixel_data_valid_out (s_v),
        .frame_done_out       (s_d)
    );

    line_window_3x3 u_big (
        .clk_in               (clk),
        .rst_in               (rst),
        .pixel_in             (pix),
        .pixel_valid_in       (pv & sel),
        .pixel_sof_in         (psof),
        .pixel_data_out       (b_data),
        .pixel_data_valid_out (b_v),
        .frame_done_out       (b_d)
    );

    assign m_data  = sel ? b_data : s_data;
    assign m_valid = sel ? b_v    : s_v;
    assign m_done  = sel ? b_d    : s_d;

    typedef struct {
        logic [7:0]  pix;
        logic        sof;
        logic        exp_v;
        logic [71:0] exp_win;
        logic        exp_done;
    } vec_t;

    typedef struct {
        longint      cyc;
        logic [71:0] win;
        logic        done;
    } exp_t;

    vec_t   tbl [12];
    exp_t   q [$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     win_cnt = 0;
    int     done_cnt = 0;
    bit     mon_en = 1'b0;

    // Reference frame model: keeps the whole image and cuts windows from it.
    logic [7:0] img [0:119][0:159];
    int         cur_w, cur_h;
    int         m_row, m_col;
    bit         m_act;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_window at cyc %0d: no output, required %h", q[0].cyc, q[0].win);
                void'(q.pop_front());
            end
            if (m_done && !m_valid) begin
                checks++; errors++;
                $display("FAIL done_without_valid cyc %0d: done=1 valid=0, required done=0", cyc);
            end
            if (m_valid) begin
                checks++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_window cyc %0d: got %h done=%b, required no window", cyc, m_data, m_done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (m_data !== e.win || m_done !== e.done) begin
                        errors++;
                        $display("FAIL window cyc %0d: got %h done=%b, required %h done=%b", cyc, m_data, m_done, e.win, e.done);
                    end
                end
                win_cnt++;
                if (m_done) done_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic [7:0] p, input logic s, input logic v);
        pix = p; psof = s; pv = v;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pix = 8'($urandom); psof = 1'($urandom); pv = 1'b0;
            step();
        end
    endtask

    task automatic model_push(input logic [7:0] p, input logic s);
        exp_t e;
        if (s) begin
            m_row = 0; m_col = 0; m_act = 1'b1;
        end
        if (m_act) begin
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                e.win = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        e.win[(3*rr+cc)*8 +: 8] = img[m_row-2+rr][m_col-2+cc];
                e.done = (m_row == cur_h-1) && (m_col == cur_w-1);
                e.cyc  = cyc + 1;
                q.push_back(e);
            end
            if (m_col == cur_w-1) begin
                m_col = 0;
                if (m_row == cur_h-1) begin
                    m_row = 0; m_act = 1'b0;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic drive_px(input logic [7:0] p, input logic s);
        model_push(p, s);
        drive_raw(p, s, 1'b1);
    endtask

    task automatic send_frame(input int gap);
        for (int r = 0; r < cur_h; r++)
            for (int c = 0; c < cur_w; c++) begin
                drive_px(8'($urandom), (r == 0) && (c == 0));
                if (gap > 0) idle(gap);
            end
    endtask

    task automatic run_table(input int gap);
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].exp_v) begin
                e.cyc = cyc + 1; e.win = tbl[i].exp_win; e.done = tbl[i].exp_done;
                q.push_back(e);
            end
            drive_raw(tbl[i].pix, tbl[i].sof, 1'b1);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pv = 1'b0;
        step(); step();
        rst = 1'b0;
        m_act = 1'b0;
    endtask

    task automatic expect_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i].pix      = 8'(i);
            tbl[i].sof      = (i == 0);
            tbl[i].exp_v    = (i >= 10);
            tbl[i].exp_win  = (i == 10) ? 72'h0A0908060504020100 :
                              (i == 11) ? 72'h0B0A09070605030201 : 72'h0;
            tbl[i].exp_done = (i == 11);
        end

        rst = 1'b1; pix = 8'h00; pv = 1'b0; psof = 1'b0; sel = 1'b0;
        cur_w = 4; cur_h = 3; m_act = 1'b0; m_row = 0; m_col = 0;
        repeat (3) step();

        checks++;
        if (s_data !== 72'h0 || s_v !== 1'b0 || s_d !== 1'b0 ||
            b_data !== 72'h0 || b_v !== 1'b0 || b_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: small %h/%b/%b big %h/%b/%b, required all 0",
                     s_data, s_v, s_d, b_data, b_v, b_d);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        // Fixed 4x3 vectors, back-to-back then with 2-cycle gaps
        win_cnt = 0; done_cnt = 0;
        run_table(0);
        idle(3);
        expect_int("table_windows", win_cnt, 2);
        expect_int("table_done", done_cnt, 1);

        win_cnt = 0; done_cnt = 0;
        run_table(2);
        idle(3);
        expect_int("gap_windows", win_cnt, 2);
        expect_int("gap_done", done_cnt, 1);

        // Pixels without sof after reset are discarded
        do_reset();
        win_cnt = 0;
        for (int i = 0; i < 10; i++) drive_px(8'($urandom), 1'b0);
        idle(2);
        expect_int("nosof_windows", win_cnt, 0);
        send_frame(0);
        idle(3);
        expect_int("nosof_frame_windows", win_cnt, 2);

        // sof at (2,3) restarts the frame without a frame_done
        win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 11; i++) drive_px(8'($urandom), i == 0);
        drive_px(8'($urandom), 1'b1);
        for (int i = 1; i < 12; i++) drive_px(8'($urandom), 1'b0);
        idle(3);
        expect_int("restart_windows", win_cnt, 3);
        expect_int("restart_done", done_cnt, 1);

        // Reset with the frame-completing pixel on the bus
        for (int i = 0; i < 11; i++) drive_px(8'($urandom), i == 0);
        pix = 8'hA5; psof = 1'b0; pv = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; pv = 1'b0; m_act = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: valid=%b done=%b, required 0/0", m_valid, m_done);
        end
        for (int i = 0; i < 5; i++) drive_px(8'($urandom), 1'b0);
        win_cnt = 0; done_cnt = 0;
        send_frame(1);
        idle(3);
        expect_int("post_reset_windows", win_cnt, 2);
        expect_int("post_reset_done", done_cnt, 1);

        // Default-size DUT, two consecutive random frames
        sel = 1'b1; cur_w = 160; cur_h = 120;
        idle(2);
        win_cnt = 0; done_cnt = 0;
        send_frame(0);
        send_frame(0);
        idle(3);
        expect_int("big_windows", win_cnt, 2 * 158 * 118);
        expect_int("big_done", done_cnt, 2);

        expect_int("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
